// File: rtl/fpadd_pkg.sv
// Shared constants and types for the FP-add scheduler and its result buffer.
package fpadd_pkg;

  localparam int FP_W               = 32;
  localparam int ID_W               = 1;
  localparam int DEF_STAGES         = 4;
  localparam int DEF_FIFO_DEPTH     = 2;
  localparam int CNT_W              = 16;

  typedef enum logic [ID_W-1:0] {
    RQ0 = 1'b0,
    RQ1 = 1'b1
  } req_id_e;

  // Result buffer entry: datapath result tagged with the issuing requester.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [FP_W-1:0] data;
  } res_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fpadd_res_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is accepted only alongside a pop.
module fpadd_res_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: only entries covered by cnt are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fpadd_sched.sv
// Two-requester round-robin scheduler for a shared STAGES-deep FP-add pipeline.
// Optional FPADD_SCHED_PERF_EN adds saturating issue/stall counters.
module fpadd_sched
  import fpadd_pkg::*;
#(
  parameter int STAGES     = DEF_STAGES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic            pipe_en,
  output logic [FP_W-1:0] pipe_a,
  output logic [FP_W-1:0] pipe_b,
  input  logic [FP_W-1:0] pipe_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data,
  output logic [ID_W-1:0] out_id
`ifdef FPADD_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] id_pipe;
  req_id_e         rr_last;
  logic            gnt_vld;
  req_id_e         gnt_id;
  logic            fifo_full, fifo_empty, pop, push;
  res_t            wr_ent, head;

  assign pop     = out_valid && out_ready;
  assign pipe_en = rst_n && !(vld_pipe[STAGES] && fifo_full && !pop);
  assign push    = pipe_en && vld_pipe[STAGES];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = RQ0;
    if (pipe_en) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = (rr_last == RQ0) ? RQ1 : RQ0;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = RQ0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = RQ1;
      end
    end
  end

  assign req0_ready = gnt_vld && (gnt_id == RQ0);
  assign req1_ready = gnt_vld && (gnt_id == RQ1);
  assign pipe_a     = !gnt_vld ? '0 : (gnt_id == RQ1) ? req1_a : req0_a;
  assign pipe_b     = !gnt_vld ? '0 : (gnt_id == RQ1) ? req1_b : req0_b;

  // Valid/id bits track the datapath stage registers one-for-one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      rr_last  <= RQ1;
    end else begin
      if (pipe_en) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], gnt_vld};
        id_pipe  <= {id_pipe[STAGES-1:1], gnt_id[0]};
      end
      if (gnt_vld) rr_last <= gnt_id;
    end
  end

  always_comb begin
    wr_ent      = '0;
    wr_ent.data = pipe_res;
    wr_ent.id   = id_pipe[STAGES];
  end

  fpadd_res_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = rst_n && !fifo_empty;
  assign out_data  = rst_n ? head.data : '0;
  assign out_id    = rst_n ? head.id : '0;

`ifdef FPADD_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt_vld) issue_cnt <= sat_inc(issue_cnt);
      if (!pipe_en && vld_pipe[STAGES]) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fpadd_sched.sv
// Scoreboard bench for fpadd_sched: behavioural arbitration/occupancy model plus an in-order result checker.
module tb_fpadd_sched;

  localparam int S  = 4;
  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        pipe_en;
  logic [31:0] pipe_a, pipe_b, pipe_res;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [0:0]  out_id;
`ifdef FPADD_SCHED_PERF_EN
  logic [15:0] issue_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  fpadd_sched #(.STAGES(S), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .pipe_en(pipe_en), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_res(pipe_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
`ifdef FPADD_SCHED_PERF_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Datapath stand-in: S enable-gated stages computing a tag from the operands.
  logic [31:0] dp [1:S];
  assign pipe_res = dp[S];
  always @(posedge clk) if (pipe_en) begin
    for (int i = S; i > 1; i--) dp[i] <= dp[i-1];
    dp[1] <= pipe_a + pipe_b;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] d; logic id; } exp_t;
  exp_t sb[$];
  bit   gseq[$];

  // Reference model: occupancy of each pipeline slot, result-buffer count, last grant.
  bit          mslot [1:S];
  int          mcnt = 0;
  bit          mlast = 1'b1;
  int          acc0 = 0;
  bit          hold = 0;
  logic [31:0] hold_d;
  logic        hold_id;
  int          nout = 0;
`ifdef FPADD_SCHED_PERF_EN
  int m_issue = 0, m_stall = 0;
`endif

  always @(negedge clk) begin
    bit pop, en, g0, g1;
    exp_t e;
    logic [31:0] ea, eb;
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_pipe_en", pipe_en, 0);
      for (int i = 1; i <= S; i++) mslot[i] = 0;
      mcnt = 0; mlast = 1'b1; hold = 0;
      sb.delete();
`ifdef FPADD_SCHED_PERF_EN
      m_issue = 0; m_stall = 0;
`endif
    end else begin
      pop = (mcnt > 0) && out_ready;
      en  = !(mslot[S] && mcnt == FD && !pop);
      g0  = en && req0_valid && (!req1_valid || mlast);
      g1  = en && req1_valid && (!req0_valid || !mlast);
      ea  = g0 ? req0_a : g1 ? req1_a : 32'h0;
      eb  = g0 ? req0_b : g1 ? req1_b : 32'h0;
      chk("pipe_en", pipe_en, en);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("pipe_a", pipe_a, ea);
      chk("pipe_b", pipe_b, eb);
      chk("out_valid", out_valid, mcnt > 0);
      if (hold) begin
        chk("hold_data", out_data, hold_d);
        chk("hold_id", out_id, hold_id);
      end
      if (g0 || g1) begin
        e.d = ea + eb; e.id = g1;
        sb.push_back(e);
        gseq.push_back(g1);
        mlast = g1;
        if (g0) acc0++;
      end
`ifdef FPADD_SCHED_PERF_EN
      if ((g0 || g1) && m_issue < 65535) m_issue++;
      if (!en && mslot[S] && m_stall < 65535) m_stall++;
`endif
      if (en) begin
        if (mslot[S]) mcnt++;
        for (int i = S; i > 1; i--) mslot[i] = mslot[i-1];
        mslot[1] = g0 || g1;
      end
      if (pop) mcnt--;
      hold = out_valid && !out_ready;
      hold_d = out_data; hold_id = out_id;
    end
  end

  // Monitor: every accepted output must match the oldest outstanding issue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      nout++;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out actual=%0h required=none t=%0t", out_data, $time);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_id", out_id, e.id);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1; req0_valid = 0; req1_valid = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin step(); t++; end
    chk("drain_timeout", t < 200, 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0; step(n); rst_n = 1;
  endtask

  initial begin
    int lat;
    bit exp_seq [6];
    exp_seq = '{0, 1, 0, 1, 0, 1};
    req0_valid = 1; req1_valid = 1;
    do_reset(3);
    req0_valid = 0; req1_valid = 0;
    step(2);

    // Single request, latency from acceptance edge.
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    #3 chk("single_pipe_a", pipe_a, 32'h3F800000);
    step(); req0_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    chk("latency", lat, S);
    chk("single_id", out_id, 0);
    drain();

    // Contention from a fresh reset: grants alternate starting with requester 0.
    do_reset(1);
    gseq.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      step();
    end
    req0_valid = 0; req1_valid = 0;
    chk("contention_len", gseq.size(), 6);
    for (int i = 0; i < 6 && i < gseq.size(); i++) chk("contention_seq", gseq[i], exp_seq[i]);
    drain();

    // Backpressure: exactly S+FD accepts before the pipe stalls.
    acc0 = 0; out_ready = 0; req0_valid = 1;
    for (int i = 0; i < 12; i++) begin req0_a = $urandom; req0_b = $urandom; step(); end
    chk("bp_accepts", acc0, S + FD);
    chk("bp_pipe_en", pipe_en, 0);
    chk("bp_ready0", req0_ready, 0);
    // Full buffer with last stage valid: concurrent push and pop keep streaming.
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin req0_a = $urandom; req0_b = $urandom; step(); end
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      req0_valid = $urandom_range(0, 1); req1_valid = $urandom_range(0, 1);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    // Reset mid-flight: three ops in the pipe are discarded.
    req0_valid = 1; req1_valid = 0;
    for (int i = 0; i < 3; i++) begin req0_a = $urandom; req0_b = $urandom; step(); end
    req0_valid = 0;
    do_reset(1);
    nout = 0;
    step(S + 4);
    chk("flush_no_out", nout, 0);
    req0_valid = 1; req1_valid = 1;
    #1 chk("post_rst_tie_r0", req0_ready, 1);
    chk("post_rst_tie_r1", req1_ready, 0);
    step(); req0_valid = 0; req1_valid = 0;
    drain();

`ifdef FPADD_SCHED_PERF_EN
    do_reset(1);
    out_ready = 0; req0_valid = 1;
    step(5); req0_valid = 0; step(8);
    chk("perf_issue5", issue_cnt, 5);
    chk("perf_stall", stall_cnt, 16'(m_stall));
    drain();
    req0_valid = 1;
    step(70000);
    req0_valid = 0;
    chk("perf_issue_sat", issue_cnt, 16'hFFFF);
    drain();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 Parameter STAGES, default 4: number of pipeline stages in the shared FP-add datapath (legal 2..8).
REQ-002 Parameter FIFO_DEPTH, default 2: result buffer entries (power of two, 2..8).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 operation pending.
REQ-006 req0_ready / req1_ready  out  1  requester 0/1 operation accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  32  IEEE-754 single operands.
REQ-008 pipe_en  out  1  advance all datapath stage registers this cycle.
REQ-009 pipe_a, pipe_b  out  32  operands muxed from the granted requester into datapath stage 1.
REQ-010 pipe_res  in  32  datapath last-stage result.
REQ-011 out_valid  out  1; out_ready  in  1; out_data  out  32; out_id  out  1 (requester that issued the result).

Function
REQ-012 Controller SHALL keep a per-stage valid bit and id bit (STAGES entries) mirroring the datapath.
REQ-013 pipe_en SHALL be 1 unless stage STAGES is valid and the result FIFO is full with no pop this cycle.
REQ-014 On pipe_en, valid/id SHALL shift one stage; stage 1 loads grant-valid and grant-id.
REQ-015 On pipe_en with stage STAGES valid, pipe_res and its id SHALL be written to the FIFO.
REQ-016 Grant SHALL occur only when pipe_en=1; at most one reqN_ready high per cycle.
REQ-017 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-018 Round-robin pointer SHALL update only on a grant.
REQ-019 pipe_a/pipe_b SHALL equal the granted requester's operands; 0 when no grant.
REQ-020 Latency: accepted at edge T, result SHALL appear at out_valid after edge T+STAGES when pipeline and FIFO are unblocked.
REQ-021 out_valid SHALL equal FIFO non-empty; out_data/out_id SHALL show the FIFO head; pop on out_valid && out_ready.
REQ-022 Simultaneous FIFO push and pop when full SHALL be legal and keep the count unchanged.
REQ-023 out_data/out_id SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 Results SHALL leave in issue order; no result SHALL be dropped or duplicated.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 While rst_n=0 at a clock edge: all stage valids, FIFO count and pointers SHALL clear; round-robin pointer SHALL favour requester 0.
REQ-027 During reset cycles reqN_ready=0, out_valid=0, out_data=0, out_id=0, pipe_en=0.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered results; none SHALL emerge after reset release.

Configuration
REQ-029 Macro FPADD_SCHED_PERF_EN: when defined, add outputs issue_cnt[15:0] (grants) and stall_cnt[15:0] (cycles with pipe_en=0 and stage STAGES valid), both saturating, cleared by reset.
REQ-030 Without FPADD_SCHED_PERF_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package fpadd_pkg SHALL hold the 32-bit float width constant, the id width constant and the default STAGES/FIFO_DEPTH values.
REQ-032 Result buffer SHALL be a sub-module fpadd_res_fifo (synchronous FIFO, width 33: data+id).

Verification
REQ-033 Single request: req0 1.0+2.0 at cycle 0, out_ready=1 -> out_valid at cycle 4 (STAGES=4), out_id=0, pipe_a=0x3F800000 at issue.
REQ-034 Contention: both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; results in same order.
REQ-035 Backpressure: out_ready=0, req0 streams -> accept exactly STAGES+FIFO_DEPTH ops (6), then pipe_en=0, reqN_ready=0, out_data stable.
REQ-036 Full push/pop: FIFO full, stage 4 valid, out_ready=1 -> pipe_en=1, count stays 2, no loss.
REQ-037 Reset mid-flight: 3 ops in pipe, rst_n low one cycle -> out_valid never asserts for them; next request served by req0 on tie.
REQ-038 PERF_EN build: 5 grants, 3 stall cycles -> issue_cnt=5, stall_cnt=3; 70000 grants -> issue_cnt=0xFFFF.
